// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: FSM states,
// instruction classes, opcode field values, ALU function and flag-select codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_BRANCH,
    OP_JMP,
    OP_LD,
    OP_ST,
    OP_NOP,
    OP_HALT
  } op_t;

  // ins[15:14] class field
  localparam logic [1:0] OPC_ALU    = 2'b00;
  localparam logic [1:0] OPC_BRANCH = 2'b01;
  localparam logic [1:0] OPC_JMP    = 2'b10;
  // ins[15:12] for the 11xx group
  localparam logic [3:0] OPC_LD     = 4'b1100;
  localparam logic [3:0] OPC_ST     = 4'b1101;
  localparam logic [3:0] OPC_NOP    = 4'b1110;

  localparam logic [2:0] FUNC_ADD   = 3'b000;

  localparam logic [1:0] CC_Z = 2'b00;
  localparam logic [1:0] CC_C = 2'b01;
  localparam logic [1:0] CC_V = 2'b10;
  localparam logic [1:0] CC_S = 2'b11;

  // Classify the 5-bit opcode field ins[15:11].
  function automatic op_t decode_op(input logic [4:0] opf);
    op_t op;
    op = OP_HALT;
    case (opf[4:3])
      OPC_ALU:    op = OP_ALU;
      OPC_BRANCH: op = OP_BRANCH;
      OPC_JMP:    op = OP_JMP;
      default: begin
        case (opf[4:1])
          OPC_LD:  op = OP_LD;
          OPC_ST:  op = OP_ST;
          OPC_NOP: op = OP_NOP;
          default: op = OP_HALT;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: selects one datapath flag by cc and
// optionally inverts it (n=1 means branch when the flag is clear).
module branch_cond
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  input  logic       s,
  output logic       taken
);

  logic flag;

  // Pick the flag named by cond[2:1], then apply the sense bit cond[0].
  always_comb begin
    flag = z;
    case (cond[2:1])
      CC_Z: flag = z;
      CC_C: flag = c;
      CC_V: flag = v;
      CC_S: flag = s;
    endcase
    taken = flag ^ cond[0];
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle FSM controller for the 16-bit CPU datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB over a single memory port with a req/ready
// handshake guarded by a wait-cycle watchdog. Strobes are decoded
// combinationally from the state so that reset clears them immediately
// and the fetch/memory completions can respond in the mem_ready cycle.
module multi_cycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int INS_W        = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins,
  input  logic             Zin,
  input  logic             Cin,
  input  logic             Vin,
  input  logic             Sin,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             pc_src,
  output logic             read1,
  output logic             read2,
  output logic             write,
  output logic             wb_sel,
  output logic [2:0]       func_select,
  output logic             alu_imm,
  output logic             flags_ld,
  output logic             halted,
  output logic             bus_err
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  // Value held by the counter during the last permitted wait cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             bus_err_q;
  logic             timeout;
  logic             taken;
  op_t              op;
  logic             unused_ins;

  assign op         = decode_op(ins[INS_W-1 -: 5]);
  assign unused_ins = ^ins[INS_W-7:0];
  assign bus_err    = bus_err_q;

  branch_cond u_branch_cond (
    .cond  (ins[INS_W-3 -: 3]),
    .z     (Zin),
    .c     (Cin),
    .v     (Vin),
    .s     (Sin),
    .taken (taken)
  );

  // Next-state, watchdog and per-cycle strobe decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    timeout      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    pc_src       = 1'b0;
    read1        = 1'b0;
    read2        = 1'b0;
    write        = 1'b0;
    wb_sel       = 1'b0;
    func_select  = 3'b000;
    alu_imm      = 1'b0;
    flags_ld     = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_RST: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        read1 = 1'b1;
        read2 = 1'b1;
        case (op)
          OP_BRANCH: begin
            pc_ld     = taken;
            state_nxt = ST_FETCH;
          end
          OP_JMP: begin
            pc_ld     = 1'b1;
            pc_src    = 1'b1;
            state_nxt = ST_FETCH;
          end
          OP_NOP:  state_nxt = ST_FETCH;
          OP_HALT: state_nxt = ST_HALT;
          default: state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (op == OP_ALU) begin
          func_select = ins[INS_W-3 -: 3];
          alu_imm     = ins[INS_W-6];
          state_nxt   = ST_WB;
        end else if (op == OP_LD || op == OP_ST) begin
          // Effective address = base register + sext(offset)
          func_select = FUNC_ADD;
          alu_imm     = 1'b1;
          state_nxt   = ST_MEM;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op == OP_ST);
        if (mem_ready) begin
          state_nxt = (op == OP_LD) ? ST_WB : ST_FETCH;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_WB: begin
        write     = 1'b1;
        wb_sel    = (op == OP_LD);
        flags_ld  = (op == OP_ALU);
        state_nxt = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_RST;
    endcase
  end

  // State register, watchdog counter and sticky bus error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RST;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: a directed vector table,
// a randomized instruction stream against a per-instruction trace model,
// and hand-written reset, watchdog and halt sequences.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       pc_src;
    logic       read1;
    logic       read2;
    logic       write;
    logic       wb_sel;
    logic [2:0] func;
    logic       alu_imm;
    logic       flags_ld;
    logic       halted;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  flags;
    outs_t       dec;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ins;
  logic        z_in, c_in, v_in, s_in;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, pc_src;
  logic        read1, read2, write, wb_sel, alu_imm, flags_ld, halted, bus_err;
  logic [2:0]  func_select;
  outs_t       obs;

  int    total = 0;
  int    bad   = 0;
  step_t trace[$];
  vec_t  vecs[11];

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, pc_src, read1, read2,
                write, wb_sel, func_select, alu_imm, flags_ld, halted, bus_err};

  multi_cycle_controller #(.INS_W(16), .MEM_WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .Zin         (z_in),
    .Cin         (c_in),
    .Vin         (v_in),
    .Sin         (s_in),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .pc_src      (pc_src),
    .read1       (read1),
    .read2       (read2),
    .write       (write),
    .wb_sel      (wb_sel),
    .func_select (func_select),
    .alu_imm     (alu_imm),
    .flags_ld    (flags_ld),
    .halted      (halted),
    .bus_err     (bus_err)
  );

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic outs_t dec_exp(input logic pl, input logic ps);
    outs_t e;
    e = '0;
    e.read1  = 1'b1;
    e.read2  = 1'b1;
    e.pc_ld  = pl;
    e.pc_src = ps;
    return e;
  endfunction

  function automatic outs_t fetch_done();
    outs_t e;
    e = '0;
    e.mem_req = 1'b1;
    e.ir_ld   = 1'b1;
    e.pc_inc  = 1'b1;
    return e;
  endfunction

  task automatic push(input logic r, input outs_t e);
    step_t s;
    s.rdy = r;
    s.exp = e;
    trace.push_back(s);
  endtask

  // One memory access: d stalled cycles then a completing cycle.
  task automatic mem_phase(input int d, input logic is_fetch, input logic we);
    outs_t e;
    e = '0;
    e.mem_req = 1'b1;
    if (!is_fetch) begin
      e.addr_sel = 1'b1;
      e.mem_we   = we;
    end
    for (int k = 0; k < d; k++) push(1'b0, e);
    if (is_fetch) begin
      e.ir_ld  = 1'b1;
      e.pc_inc = 1'b1;
    end
    push(1'b1, e);
  endtask

  // Expected cycle trace of one instruction, from DECODE through the
  // completion of the following fetch. f = {Z,C,V,S}.
  task automatic model(input logic [15:0] i, input logic [3:0] f, input int dmem, input int dfetch);
    int    op5, cc, n;
    logic  st;
    outs_t e;
    trace.delete();
    op5 = int'(i[15:11]);
    e = dec_exp(1'b0, 1'b0);
    if (op5 >= 8 && op5 < 16) begin
      cc = (op5 / 2) % 4;
      n  = op5 % 2;
      e.pc_ld = (int'(f[3-cc]) != n);
    end else if (op5 >= 16 && op5 < 24) begin
      e.pc_ld  = 1'b1;
      e.pc_src = 1'b1;
    end
    push(1'($urandom), e);
    if (op5 >= 30) begin
      e = '0;
      e.halted = 1'b1;
      for (int k = 0; k < 4; k++) push(1'($urandom), e);
      return;
    end
    if (op5 < 8) begin
      e = '0;
      e.func    = i[13:11];
      e.alu_imm = i[10];
      push(1'($urandom), e);
      e = '0;
      e.write    = 1'b1;
      e.flags_ld = 1'b1;
      push(1'($urandom), e);
    end else if (op5 >= 24 && op5 < 28) begin
      st = (op5 >= 26);
      e = '0;
      e.alu_imm = 1'b1;
      push(1'($urandom), e);
      mem_phase(dmem, 1'b0, st);
      if (!st) begin
        e = '0;
        e.write  = 1'b1;
        e.wb_sel = 1'b1;
        push(1'($urandom), e);
      end
    end
    mem_phase(dfetch, 1'b1, 1'b0);
  endtask

  task automatic run_trace(input logic [15:0] i, input logic [3:0] f, input string name);
    foreach (trace[k]) begin
      @(posedge clk); #1;
      if (k == 0) begin
        ins = i;
        {z_in, c_in, v_in, s_in} = f;
      end
      mem_ready = trace[k].rdy;
      @(negedge clk);
      chk($sformatf("%s ins=%h step%0d", name, i, k), obs, trace[k].exp);
    end
  endtask

  // Assert reset, check it clears outputs at once, then reach a completed fetch.
  task automatic do_reset(input string tag);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_async"}, obs, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_state"}, obs, '0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_first_fetch"}, obs, fetch_done());
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    outs_t d;
    int    n;
    @(posedge clk); #1;
    ins = v.ins;
    {z_in, c_in, v_in, s_in} = v.flags;
    mem_ready = 1'b1;
    @(negedge clk);
    d = obs;
    n = 1;
    while (n < 10) begin
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      n++;
      if (obs.ir_ld) break;
    end
    chk($sformatf("vec%0d_decode ins=%h", idx, v.ins), d, v.dec);
    chk_int($sformatf("vec%0d_latency ins=%h", idx, v.ins), n, v.lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    outs_t       e;
    logic [4:0]  op5;
    logic [15:0] ri;
    logic [3:0]  rf;

    vecs[0]  = '{16'h0035, 4'b0000, dec_exp(1'b0, 1'b0), 4};
    vecs[1]  = '{16'h4035, 4'b1000, dec_exp(1'b1, 1'b0), 2};
    vecs[2]  = '{16'h4035, 4'b0111, dec_exp(1'b0, 1'b0), 2};
    vecs[3]  = '{16'h4835, 4'b0000, dec_exp(1'b1, 1'b0), 2};
    vecs[4]  = '{16'h5035, 4'b0100, dec_exp(1'b1, 1'b0), 2};
    vecs[5]  = '{16'h6835, 4'b0010, dec_exp(1'b0, 1'b0), 2};
    vecs[6]  = '{16'h7035, 4'b0001, dec_exp(1'b1, 1'b0), 2};
    vecs[7]  = '{16'h8035, 4'b0000, dec_exp(1'b1, 1'b1), 2};
    vecs[8]  = '{16'hC035, 4'b0000, dec_exp(1'b0, 1'b0), 5};
    vecs[9]  = '{16'hD035, 4'b0000, dec_exp(1'b0, 1'b0), 4};
    vecs[10] = '{16'hE035, 4'b1111, dec_exp(1'b0, 1'b0), 2};

    rst = 1'b1;
    ins = 16'h0000;
    {z_in, c_in, v_in, s_in} = 4'b0000;
    mem_ready = 1'b0;
    #2;
    do_reset("init");

    for (int k = 0; k < 11; k++) apply_vec(vecs[k], k);

    model(16'hC035, 4'b0000, 3, 0);
    run_trace(16'hC035, 4'b0000, "ld_wait3");

    for (int k = 0; k < 40; k++) begin
      op5 = 5'($urandom_range(0, 29));
      ri  = {op5, 11'($urandom)};
      rf  = 4'($urandom);
      model(ri, rf, $urandom_range(0, 4), $urandom_range(0, 4));
      run_trace(ri, rf, "rand");
    end

    // Reset in the middle of a stalled load access
    @(posedge clk); #1;
    ins = 16'hC035;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("midmem_decode", obs, dec_exp(1'b0, 1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    e = '0;
    e.alu_imm = 1'b1;
    chk("midmem_exec", obs, e);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    e = '0;
    e.mem_req  = 1'b1;
    e.addr_sel = 1'b1;
    chk("midmem_req", obs, e);
    do_reset("midmem");

    // Fetch that never completes trips the watchdog
    @(posedge clk); #1;
    ins = 16'hE035;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wd_nop_decode", obs, dec_exp(1'b0, 1'b0));
    e = '0;
    e.mem_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("wd_wait%0d", k), obs, e);
    end
    e = '0;
    e.halted  = 1'b1;
    e.bus_err = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_ready = k[0];
      @(negedge clk);
      chk($sformatf("wd_halted%0d", k), obs, e);
    end
    do_reset("wd");

    model(16'hF800, 4'b0000, 0, 0);
    run_trace(16'hF800, 4'b0000, "halt");
    do_reset("halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
